ps2_kbd_rx: RTL and testbench



---
 rtl/ps2_kbd_rx.sv | 173 +++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 bus, deserialises and validates
// 11-bit frames, and buffers scan codes in a first-word-fall-through FIFO for MMIO reads.
module ps2_kbd_rx #(
  parameter int KB_WIDTH    = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int PTR_W       = 3,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                sig_rd_kb,
  output logic [KB_WIDTH-1:0] kb_rdata,
  output logic                kb_ready,
  output logic                overflow,
  output logic                frame_err
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK
  } state_t;

  logic [2:0]          ps2c_q;
  logic [1:0]          ps2d_q;
  logic                ps2_fall;
  logic                ps2_bit;

  state_t              state_q;
  logic [3:0]          bitcnt_q;
  logic [9:0]          shift_q;
  logic [TO_W-1:0]     to_q;
  logic                frame_err_q;
  logic                frame_ok;
  logic                push_req;

  logic [KB_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                pop;
  logic                push;
  logic                full;

  // Synchroniser flops reset to 1 so the idle-high bus never looks like an edge.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ps2c_q <= '1;
      ps2d_q <= '1;
    end else begin
      ps2c_q <= {ps2c_q[1:0], ps2_clk};
      ps2d_q <= {ps2d_q[0], ps2_data};
    end
  end

  assign ps2_fall = ps2c_q[2] & ~ps2c_q[1];
  assign ps2_bit  = ps2d_q[1];

  // shift_q fills from the top, so after the stop bit: [7:0]=data, [8]=parity, [9]=stop.
  assign frame_ok = shift_q[9] & (^shift_q[8:0]);
  assign push_req = (state_q == S_CHECK) & frame_ok;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      to_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          to_q <= '0;
          if (ps2_fall && !ps2_bit) begin
            state_q  <= S_RECV;
            bitcnt_q <= 4'd1;
          end
        end
        S_RECV: begin
          if (ps2_fall) begin
            shift_q  <= {ps2_bit, shift_q[9:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            to_q     <= '0;
            if (bitcnt_q == 4'd10) begin
              state_q <= S_CHECK;
            end
          end else if (to_q == TO_LAST) begin
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            to_q        <= '0;
          end else begin
            to_q <= to_q + TO_ONE;
          end
        end
        S_CHECK: begin
          if (!frame_ok) begin
            frame_err_q <= 1'b1;
          end
          state_q  <= S_IDLE;
          bitcnt_q <= '0;
        end
        default: begin
          state_q  <= S_IDLE;
          bitcnt_q <= '0;
          to_q     <= '0;
        end
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    pop   = sig_rd_kb & (cnt_q != '0);
    full  = (cnt_q == FULL_CNT);
    push  = push_req & (~full | pop);
    cnt_d = cnt_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (push) begin
      wr_d = wr_q + PTR_ONE;
    end
    if (pop) begin
      rd_d = rd_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn && push) begin
      mem_q[wr_q] <= KB_WIDTH'(shift_q[7:0]);
    end
  end

  assign kb_ready  = (cnt_q != '0);
  assign kb_rdata  = kb_ready ? mem_q[rd_q] : '0;
  assign overflow  = ovf_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames are bit-banged on the PS/2 pins and the FIFO
// head, ready, overflow and error-pulse count are compared against hand-worked values.
module tb_ps2_kbd_rx;

  localparam int HALF = 10;

  logic       clk;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       sig_rd_kb;
  logic [7:0] kb_rdata;
  logic       kb_ready;
  logic       overflow;
  logic       frame_err;

  int checks;
  int errors;
  int err_pulses;

  ps2_kbd_rx #(
    .KB_WIDTH   (8),
    .FIFO_DEPTH (8),
    .PTR_W      (3),
    .TIMEOUT_CYC(2000)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .sig_rd_kb(sig_rd_kb),
    .kb_rdata (kb_rdata),
    .kb_ready (kb_ready),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clrn && frame_err) err_pulses++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // {stop, parity, data, start}; parity is odd unless flipped.
  function automatic logic [10:0] mk(input logic [7:0] d, input logic flip, input logic stop);
    logic par;
    par = ~(^d) ^ flip;
    return {stop, par, d, 1'b0};
  endfunction

  task automatic ps2_edge(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain; 1: check push latency after last edge; 2: pop in the push cycle
  task automatic send(input logic [10:0] f, input int nbits, input int mode);
    for (int i = 0; i < nbits - 1; i++) ps2_edge(f[i]);
    ps2_data = f[nbits-1];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1 chk("lat_notyet", {31'd0, kb_ready}, 32'd0);
      @(posedge clk);
      #1 chk("lat_ready", {31'd0, kb_ready}, 32'd1);
      chk("lat_data", {24'd0, kb_rdata}, {24'd0, f[8:1]});
    end else if (mode == 2) begin
      repeat (3) @(posedge clk);
      @(negedge clk) sig_rd_kb = 1'b1;
      @(negedge clk) sig_rd_kb = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, kb_rdata}, {24'd0, exp});
    @(negedge clk) sig_rd_kb = 1'b1;
    @(negedge clk) sig_rd_kb = 1'b0;
  endtask

  initial begin
    int e0;
    checks     = 0;
    errors     = 0;
    err_pulses = 0;
    clrn       = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    sig_rd_kb  = 1'b0;
    repeat (4) @(negedge clk);
    clrn = 1'b1;
    repeat (4) @(negedge clk);

    chk("rst_ready", {31'd0, kb_ready}, 32'd0);
    chk("rst_data", {24'd0, kb_rdata}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);

    // 0x1C: bits 0,0,1,1,1,0,0,0, parity 0, stop 1
    send(11'b1_0_00011100_0, 11, 1);
    pop_chk("first_head", 8'h1C);
    chk("first_empty", {31'd0, kb_ready}, 32'd0);
    chk("first_zero", {24'd0, kb_rdata}, 32'd0);
    chk("first_noerr", err_pulses, 32'd0);

    e0 = err_pulses;
    send(mk(8'h1C, 1'b1, 1'b1), 11, 0);
    chk("par_err", err_pulses - e0, 32'd1);
    chk("par_nopush", {31'd0, kb_ready}, 32'd0);
    send(mk(8'hF0, 1'b0, 1'b0), 11, 0);
    chk("stop_err", err_pulses - e0, 32'd2);
    chk("stop_nopush", {31'd0, kb_ready}, 32'd0);

    // one entry held, pop lands in the push cycle
    send(mk(8'h11, 1'b0, 1'b1), 11, 0);
    send(mk(8'h22, 1'b0, 1'b1), 11, 2);
    chk("pp1_ready", {31'd0, kb_ready}, 32'd1);
    pop_chk("pp1_head", 8'h22);
    chk("pp1_cnt1", {31'd0, kb_ready}, 32'd0);

    // full FIFO, pop lands in the push cycle: no overflow
    for (int i = 0; i < 8; i++) send(mk(8'h31 + 8'(i), 1'b0, 1'b1), 11, 0);
    send(mk(8'h39, 1'b0, 1'b1), 11, 2);
    chk("ppf_noovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) pop_chk("ppf_head", 8'h32 + 8'(i));
    chk("ppf_empty", {31'd0, kb_ready}, 32'd0);

    // overflow: 9 frames, no reads
    for (int i = 1; i <= 9; i++) send(mk(8'(i), 1'b0, 1'b1), 11, 0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) pop_chk("ovf_head", 8'(i));
    chk("ovf_empty", {31'd0, kb_ready}, 32'd0);
    sig_rd_kb = 1'b1;
    repeat (2) @(negedge clk);
    sig_rd_kb = 1'b0;
    chk("rd_empty_nop", {31'd0, kb_ready}, 32'd0);
    send(mk(8'h0A, 1'b0, 1'b1), 11, 0);
    pop_chk("wrap_head", 8'h0A);
    chk("wrap_empty", {31'd0, kb_ready}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // timeout after start + 4 bits
    e0 = err_pulses;
    send(mk(8'h5A, 1'b0, 1'b1), 5, 0);
    repeat (2050) @(negedge clk);
    chk("to_err", err_pulses - e0, 32'd1);
    chk("to_nopush", {31'd0, kb_ready}, 32'd0);
    send(mk(8'h5A, 1'b0, 1'b1), 11, 0);
    chk("to_after", err_pulses - e0, 32'd1);
    pop_chk("to_next", 8'h5A);

    // reset mid-frame with 3 entries buffered
    send(mk(8'h41, 1'b0, 1'b1), 11, 0);
    send(mk(8'h42, 1'b0, 1'b1), 11, 0);
    send(mk(8'h43, 1'b0, 1'b1), 11, 0);
    chk("mr_buf", {31'd0, kb_ready}, 32'd1);
    send(mk(8'h55, 1'b0, 1'b1), 4, 0);
    clrn = 1'b0;
    @(negedge clk) clrn = 1'b1;
    chk("mr_ready", {31'd0, kb_ready}, 32'd0);
    chk("mr_ovf", {31'd0, overflow}, 32'd0);
    chk("mr_data", {24'd0, kb_rdata}, 32'd0);
    repeat (5) @(negedge clk);
    send(mk(8'h29, 1'b0, 1'b1), 11, 0);
    pop_chk("mr_next", 8'h29);
    chk("mr_sole", {31'd0, kb_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
